sync_serial_rx: RTL
===================

// Module: sync_serial_rx
// PURPOSE
//   Synchronous serial frame receiver. Samples the single-bit line D on the
//   rising edge of CK, frames it as start(0) / WIDTH data bits LSB-first /
//   stop(1), and presents each completed word on Q with a one-cycle VALID strobe.
//   Sink end of the one-bit D/CK stimulus path. Feeds capture/check logic in
//   the chapter benches.
// PARAMETERS
//   WIDTH   8   data bits per frame, legal range 1..32
// PORTS
//   CK     in   1      clock, all state updates on rising edge
//   RST    in   1      reset, asynchronous, active-high
//   D      in   1      serial line, idle high, synchronous to CK
//   Q      out  WIDTH  last correctly framed word
//   VALID  out  1      one-cycle strobe: Q updated this cycle
//   FERR   out  1      one-cycle strobe: stop bit sampled as 0
//   PERR   out  1      one-cycle strobe: parity mismatch (0 when macro absent)
//   BUSY   out  1      high whenever state != IDLE
// BEHAVIOUR
//   - One clock (CK). RST asynchronous, active-high. While RST=1: state=IDLE,
//     bit counter=0, shift reg=0, Q=0, VALID=0, FERR=0, PERR=0, BUSY=0.
//   - D is sampled once per rising CK edge (one bit per cycle, no oversampling).
//   - States: IDLE, DATA, [PARITY], STOP, BREAK.
//     IDLE : D=1 -> stay; D=0 -> DATA, cnt=0 (this edge consumes the start bit).
//     DATA : shreg[cnt]<=D, cnt++; on edge with cnt==WIDTH-1 -> PARITY if
//            enabled, else STOP. cnt is $clog2(WIDTH+1) bits wide and never wraps.
//     STOP : D=1 -> Q<=shreg, VALID<=1, -> IDLE.
//            D=0 -> FERR<=1, Q unchanged, -> BREAK.
//     BREAK: stay while D=0 (line held low is not a start bit); D=1 -> IDLE.
//   - VALID/FERR/PERR are registered and set on the stop/parity sampling edge.
//     Each clears on the next edge. They are never asserted together.
//   - Latency: VALID rises on the edge WIDTH+1 edges after the start-bit edge.
//     WIDTH=8: the start bit is edge 0 and VALID rises on edge 9.
//   - Back-to-back frames: a start bit on the edge right after the stop edge is
//     accepted (STOP->IDLE->DATA). No idle gap is required.
//   - Q holds its value until the next good frame. A framing or parity error,
//     or a reset of the line, does not alter Q (only RST clears it).
//   - RST mid-frame aborts the frame immediately. No strobe is produced and the
//     partial word is discarded.
// CONFIGURATION
//   SYNC_SERIAL_RX_PARITY_EN defined:
//     - One even-parity bit follows the data bits.
//     - State PARITY samples it. The frame is WIDTH+3 bits.
//     - If ^{shreg,D} != 0: PERR<=1, -> BREAK if D=0 at the next edge, else
//       IDLE; no VALID, Q unchanged.
//     - If parity is good: -> STOP.
//     - VALID latency becomes WIDTH+2 edges after the start edge.
//   SYNC_SERIAL_RX_PARITY_EN undefined:
//     - No PARITY state; PERR is tied to 0.
//     - The frame is WIDTH+2 bits, as above.
// TESTING (WIDTH=8, CK period 20ns)
//   1. RST=1 with D=1, then release -> Q=0, VALID=FERR=PERR=BUSY=0, and they
//      stay 0 for 20 idle cycles.
//   2. D=0, then 1,0,1,0,0,1,0,1, then 1 -> BUSY high from edge 0; on edge 9
//      VALID=1 for one cycle and Q=8'hA5; FERR=0.
//   3. Frame 0x5A with stop=0, D held 0 for 5 more cycles, then 1 -> FERR
//      one-cycle pulse on edge 9, Q stays 8'hA5, no VALID, BUSY low after D=1.
//   4. Frames 0x00 then 0xFF with no idle gap -> VALID pulses exactly 10
//      cycles apart, Q=8'h00 then 8'hFF.
//   5. RST pulsed 5ns during data bit 4 of 0x3C -> all outputs 0 immediately,
//      no VALID; the next full 0x3C frame gives VALID and Q=8'h3C.
//   6. Macro defined: 0x07 with parity 1 -> VALID on edge 10, Q=8'h07;
//      0x07 with parity 0 -> PERR pulse, no VALID, Q stays 8'h07.

Source files
------------

// File: rtl/sync_serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_serial_rx_if
// Purpose  : Serial line in, framed word and status strobes out.
// Revision : 1.0
// ============================================================================
interface sync_serial_rx_if #(
  parameter int WIDTH = 8
);
  logic             D;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             FERR;
  logic             PERR;
  logic             BUSY;

  modport master (output D, input Q, VALID, FERR, PERR, BUSY);
  modport slave  (input D, output Q, VALID, FERR, PERR, BUSY);
endinterface
`default_nettype wire

// File: rtl/sync_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : sync_serial_rx
// Purpose  : Start/data(LSB first)/[even parity]/stop frame receiver, one bit
//            per CK edge. Parity enabled by macro SYNC_SERIAL_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module sync_serial_rx #(
  parameter int WIDTH = 8
) (
  input  wire logic         CK,
  input  wire logic         RST,
  sync_serial_rx_if.slave   bus
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_STOP   = 3'd2,
`ifdef SYNC_SERIAL_RX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_BREAK  = 3'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
`ifdef SYNC_SERIAL_RX_PARITY_EN
  logic             perr_q, perr_d;
`endif

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SYNC_SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SYNC_SERIAL_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    q_d     = q_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef SYNC_SERIAL_RX_PARITY_EN
    perr_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!bus.D) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        // Decoded write keeps the counter (one bit wider than an index) off the select.
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CNT_W'(i)) shreg_d[i] = bus.D;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
`ifdef SYNC_SERIAL_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SYNC_SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        // A bad word goes via BREAK so a low stop slot is not taken as a start.
        if (^{shreg_q, bus.D}) begin
          perr_d  = 1'b1;
          state_d = ST_BREAK;
        end else begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bus.D) begin
          q_d     = shreg_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (bus.D) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.Q     = q_q;
  assign bus.VALID = valid_q;
  assign bus.FERR  = ferr_q;
  assign bus.BUSY  = (state_q != ST_IDLE);
`ifdef SYNC_SERIAL_RX_PARITY_EN
  assign bus.PERR  = perr_q;
`else
  assign bus.PERR  = 1'b0;
`endif

endmodule
`default_nettype wire
